// File: rtl/wb_sys_pkg.sv
// Shared Wishbone constants and slave FSM state encoding.
// Imported by every Wishbone slave in the system.
package wb_sys_pkg;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4  = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8  = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CLASSIC,
        BURST,
        ERR_RSP
    } wb_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next-word address for Wishbone incrementing/wrapping bursts.
// carry_o flags a linear burst stepping past the last word.
module wb_burst_addr_gen
    import wb_sys_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic [MEM_ADDR_BITS-1:0] cnt_i,
    input  logic [1:0]               bte_i,
    output logic [MEM_ADDR_BITS-1:0] nxt_o,
    output logic                     carry_o
);

    logic [MEM_ADDR_BITS-1:0] inc;
    logic [MEM_ADDR_BITS-1:0] mask;

    always_comb begin
        inc  = cnt_i + MEM_ADDR_BITS'(1);
        mask = '1;
        unique case (bte_i)
            WB_BTE_LINEAR: mask = '1;
            WB_BTE_WRAP4:  mask = MEM_ADDR_BITS'(3);
            WB_BTE_WRAP8:  mask = MEM_ADDR_BITS'(7);
            WB_BTE_WRAP16: mask = MEM_ADDR_BITS'(15);
        endcase
        // Wrapping bursts only step the low bits; the block stays put.
        nxt_o   = (cnt_i & ~mask) | (inc & mask);
        carry_o = (bte_i == WB_BTE_LINEAR) && (&cnt_i);
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback slave in front of an on-chip SRAM.
// Classic cycles plus CTI/BTE bursts at one beat per clock.
module wb_sram_slave
    import wb_sys_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    output logic                       ACK,
    output logic                       ERR
);

    localparam int NB    = WB_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    wb_state_e                state_q;
    logic [MEM_ADDR_BITS-1:0] cnt_q;
    logic                     ack_q;
    logic                     err_q;
    logic [WB_DATA_WIDTH-1:0] dat_r_q;

    logic [WB_ADDR_WIDTH-1:0] off;
    logic                     in_range;
    logic [MEM_ADDR_BITS-1:0] widx;
    logic [MEM_ADDR_BITS-1:0] nxt;
    logic                     carry;
    logic                     beat_ok;
    logic                     wr_en;
    logic [MEM_ADDR_BITS-1:0] rd_addr_d;
    logic [WB_DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
        off      = ADR - BASE_ADDR;
        in_range = (ADR >= BASE_ADDR)
                && ((off >> (MEM_ADDR_BITS + LSB)) == '0);
        widx     = off[LSB +: MEM_ADDR_BITS];
    end

    wb_burst_addr_gen #(
        .MEM_ADDR_BITS(MEM_ADDR_BITS)
    ) u_addr_gen (
        .cnt_i  (cnt_q),
        .bte_i  (BTE),
        .nxt_o  (nxt),
        .carry_o(carry)
    );

    assign beat_ok = ack_q && CYC && STB;
    assign wr_en   = beat_ok && WE && !rst;
    assign ACK     = ack_q && CYC && STB;
    assign ERR     = err_q && CYC && STB;
    assign DAT_R   = dat_r_q;

    // Write-first bypass so a prefetch sees this beat's bytes.
    always_comb begin
        rd_addr_d = (state_q == IDLE) ? widx : nxt;
        rd_data_d = mem[rd_addr_d];
        if (wr_en && (cnt_q == rd_addr_d)) begin
            for (int i = 0; i < NB; i++) begin
                if (SEL[i]) begin
                    rd_data_d[8*i +: 8] = DAT_W[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (SEL[i]) begin
                    mem[cnt_q][8*i +: 8] <= DAT_W[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else if (!CYC) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (STB) begin
                        if (!in_range) begin
                            state_q <= ERR_RSP;
                            err_q   <= 1'b1;
                        end else begin
                            cnt_q   <= widx;
                            ack_q   <= 1'b1;
                            dat_r_q <= rd_data_d;
                            state_q <= (CTI == WB_CTI_INCR)
                                     ? BURST : CLASSIC;
                        end
                    end
                end
                CLASSIC: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                BURST: begin
                    ack_q <= STB;
                    if (beat_ok) begin
                        if (CTI != WB_CTI_INCR) begin
                            ack_q   <= 1'b0;
                            state_q <= IDLE;
                        end else if (carry) begin
                            ack_q   <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ERR_RSP;
                        end else begin
                            cnt_q   <= nxt;
                            dat_r_q <= rd_data_d;
                        end
                    end
                end
                ERR_RSP: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: expected responses are queued
// as beats are driven and retired when ACK or ERR appears.
module tb_wb_sram_slave;
    import wb_sys_pkg::*;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        ack;
    logic        err;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [WORDS];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wb_sram_slave #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .MEM_ADDR_BITS(10),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .ADR(adr), .CTI(cti), .BTE(bte),
        .DAT_W(dat_w), .DAT_R(dat_r), .SEL(sel), .CYC(cyc),
        .STB(stb), .WE(we), .ACK(ack), .ERR(err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int beat_addr(input int start,
                                     input logic [1:0] b_te,
                                     input int b);
        int len;
        len = (b_te == 2'd1) ? 4 : (b_te == 2'd2) ? 8 :
              (b_te == 2'd3) ? 16 : 0;
        if (len == 0) return start + b;
        return (start & ~(len - 1)) | ((start + b) & (len - 1));
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (ack || err)) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(ack | err), 32'd0);
            end else begin
                e = sb.pop_front();
                check("err", 32'(err), 32'(e.err));
                check("ack", 32'(ack), 32'(!e.err));
                if (e.chk && ack) check("rdata", dat_r, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack || err) && lat < 8);
        check(tag, lat, exp_lat);
        if (!(ack || err)) sb.delete();
    endtask

    task automatic wb_classic(input bit w, input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [3:0] s, input bit exp_err);
        int   idx;
        exp_t e;
        idx   = int'((a - BASE) >> 2) & (WORDS - 1);
        cyc   = 1'b1; stb = 1'b1; we = w; adr = a;
        cti   = WB_CTI_CLASSIC; bte = WB_BTE_LINEAR;
        dat_w = d; sel = s;
        e.err = exp_err;
        e.chk = !w && !exp_err;
        e.d   = model[idx];
        sb.push_back(e);
        wait_rsp("classic_lat", 2);
        if (w && !exp_err && ack) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_burst(input bit w, input int start,
                            input logic [1:0] b_te, input int n,
                            input logic [15:0] tag,
                            input int stall_at, input int stall_len,
                            input int err_at, input int rst_at);
        int          a;
        logic [31:0] wd;
        exp_t        e;
        cyc = 1'b1; we = w; bte = b_te; sel = 4'hF;
        for (int b = 0; b < n; b++) begin
            a     = beat_addr(start, b_te, b);
            wd    = {tag, 16'(a)};
            adr   = BASE + 32'(a) * 4;
            cti   = (b == n - 1) ? WB_CTI_EOB : WB_CTI_INCR;
            stb   = 1'b1;
            dat_w = wd;
            if (b == rst_at) begin
                rst = 1'b1;
                tick();
                @(negedge clk);
                check("rst_ack", 32'(ack), 32'd0);
                check("rst_err", 32'(err), 32'd0);
                check("rst_datr", dat_r, 32'd0);
                tick();
                sb.delete();
                rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
                return;
            end
            e.err = (b == err_at);
            e.chk = !w;
            e.d   = (a < WORDS) ? model[a] : 32'd0;
            sb.push_back(e);
            wait_rsp("beat_lat", (b == 0 || b == stall_at) ? 2 : 1);
            if (w && ack && a < WORDS) model[a] = wd;
            tick();
            if (b + 1 == stall_at) begin
                stb = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_ack", 32'(ack), 32'd0);
                    tick();
                end
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = WB_CTI_CLASSIC;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_datr", dat_r, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // preload word i = i with one long linear write burst
        wb_burst(1, 0, WB_BTE_LINEAR, WORDS, 16'h0000, -1, 0, -1, -1);

        wb_classic(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        wb_classic(0, BASE + 32'h10, 32'h0, 4'hF, 0);
        wb_classic(1, BASE + 32'h10, 32'h0000_00AA, 4'h1, 0);
        wb_classic(0, BASE + 32'h10, 32'h0, 4'h0, 0);
        check("partial_model", model[4], 32'hDEAD_BEAA);

        wb_burst(0, 2, WB_BTE_WRAP4, 4, 16'h0, -1, 0, -1, -1);
        wb_burst(0, 13, WB_BTE_WRAP8, 8, 16'h0, -1, 0, -1, -1);

        wb_burst(0, 1023, WB_BTE_LINEAR, 2, 16'h0, -1, 0, 1, -1);
        wb_classic(0, BASE + 32'h0FFC, 32'h0, 4'hF, 0);

        wb_burst(0, 20, WB_BTE_LINEAR, 5, 16'h0, 1, 2, -1, -1);
        wb_burst(0, 30, WB_BTE_LINEAR, 4, 16'h0, 2, 1, -1, -1);

        wb_burst(1, 37, WB_BTE_WRAP16, 16, 16'hC0DE, -1, 0, -1, -1);
        wb_burst(0, 32, WB_BTE_LINEAR, 16, 16'h0, -1, 0, -1, -1);

        wb_classic(0, BASE - 32'h4, 32'h0, 4'hF, 1);
        wb_classic(1, BASE + 32'h1000, 32'h1234_5678, 4'hF, 1);

        wb_burst(1, 100, WB_BTE_LINEAR, 4, 16'hBAD0, -1, 0, -1, 2);
        tick();
        for (int i = 100; i < 104; i++)
            wb_classic(0, BASE + 32'(i) * 4, 32'h0, 4'hF, 0);
        check("rst_keep_102", model[102], 32'd102);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
